pool_bias_act: RTL



---
 rtl/pool_bias_act.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pool_bias_act.sv
// pool_bias_act
//   Post-processing stage behind the pooling engine. Each finished pooled beat
//   (state FINISH or COMPL) gets an optional per-lane bias add with signed
//   saturation, then an optional activation. Results are queued in a small
//   show-ahead FIFO and handed downstream over valid/ready. The pooling engine
//   cannot be stalled, so a beat arriving at a full FIFO is dropped and flagged.
//
//   Build option: define POOL_ACT_LEAKY_EN to turn the activation into a leaky
//   ReLU (negative lanes become value >>> 3) instead of clamping them to zero.
//
// Ports
//   clk, reset     : clock, asynchronous active-high reset
//   in_state       : pool state 0=INVALID 1=VALID 2=FINISH 3=COMPL
//   in_data        : pooled lanes, lane i at [i*DATA_WID +: DATA_WID]
//   in_bias        : per-lane bias, same packing
//   in_lane_mask   : 1 = lane carries a real result
//   if_bias        : add bias when 1
//   if_act         : apply activation when 1
//   out_valid      : FIFO head valid
//   out_ready      : consumer accepts head
//   out_data       : FIFO head data (0 when empty)
//   out_last       : head beat came from a COMPL input
//   overflow       : sticky, a beat was dropped
//   beat_cnt       : beats popped since the last out_last pop (saturating)

module pool_bias_act #(
    parameter int DATA_WID   = 16,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                in_state,
    input  logic [LANES*DATA_WID-1:0] in_data,
    input  logic [LANES*DATA_WID-1:0] in_bias,
    input  logic [LANES-1:0]          in_lane_mask,
    input  logic                      if_bias,
    input  logic                      if_act,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_WID-1:0] out_data,
    output logic                      out_last,
    output logic                      overflow,
    output logic [15:0]               beat_cnt
);

    localparam int DW = LANES * DATA_WID;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_FINISH = 2'd2;
    localparam logic [1:0] ST_COMPL  = 2'd3;

    // Sign-extend both operands one bit, add, then clamp on the two top bits.
    function automatic logic signed [DATA_WID-1:0] sat_add(
        input logic signed [DATA_WID-1:0] a,
        input logic signed [DATA_WID-1:0] b,
        input logic                       en
    );
        logic signed [DATA_WID:0] ae;
        logic signed [DATA_WID:0] be;
        logic signed [DATA_WID:0] s;
        ae = a;
        be = b;
        if (!en) be = '0;
        s = ae + be;
        case (s[DATA_WID -: 2])
            2'b01:   sat_add = {1'b0, {(DATA_WID-1){1'b1}}};
            2'b10:   sat_add = {1'b1, {(DATA_WID-1){1'b0}}};
            default: sat_add = s[DATA_WID-1:0];
        endcase
    endfunction

    function automatic logic signed [DATA_WID-1:0] act_lane(
        input logic signed [DATA_WID-1:0] v,
        input logic                       en,
        input logic                       m
    );
        if (!m) begin
            act_lane = '0;
        end else if (en && v[DATA_WID-1]) begin
`ifdef POOL_ACT_LEAKY_EN
            act_lane = v >>> 3;
`else
            act_lane = '0;
`endif
        end else begin
            act_lane = v;
        end
    endfunction

    logic              w_accept;
    logic [DW-1:0]     w_sat;
    logic [DW-1:0]     w_act;

    logic              r_s1_valid;
    logic              r_s1_last;
    logic              r_s1_act;
    logic [LANES-1:0]  r_s1_mask;
    logic [DW-1:0]     r_s1_data;

    logic [DW:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_wr_en;
    logic [DW:0]       w_head;

    // Partial windows (INVALID/VALID) never enter the pipeline.
    assign w_accept = (in_state == ST_FINISH) || (in_state == ST_COMPL);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_sat[g*DATA_WID +: DATA_WID] =
            sat_add(in_data[g*DATA_WID +: DATA_WID], in_bias[g*DATA_WID +: DATA_WID], if_bias);
        assign w_act[g*DATA_WID +: DATA_WID] =
            act_lane(r_s1_data[g*DATA_WID +: DATA_WID], r_s1_act, r_s1_mask[g]);
    end

    // Stage 1: bias + saturate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_s1_valid <= 1'b0;
        else       r_s1_valid <= w_accept;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_last <= (in_state == ST_COMPL);
            r_s1_act  <= if_act;
            r_s1_mask <= in_lane_mask;
            r_s1_data <= w_sat;
        end
    end

    // Stage 2: activation, FIFO write
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && out_ready;
    // A pop in the same cycle frees the slot being written, so full+pop is fine.
    assign w_wr_en = r_s1_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {r_s1_last, w_act};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            overflow <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_s1_valid && w_full && !w_pop) overflow <= 1'b1;
            if (w_pop) begin
                if (w_head[DW])                beat_cnt <= '0;
                else if (beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

    // Output: show-ahead head, zeroed while empty
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : w_head[DW-1:0];
    assign out_last  = !w_empty && w_head[DW];

endmodule
